// File: rtl/switch_egress_port.sv
// Egress end of the 4-port switch: round-robin arbiter feeding a word FIFO toward the upstream consumer.
// Latency: a word granted in cycle N is presented in cycle N+1 when the queue is empty (no bypass).
// Backpressure: ready_in low holds the head word; a full queue withholds grants unless a pop frees a slot.

module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wr_dat,
    input  logic             pop,
    output logic [W-1:0]     rd_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
endmodule

module switch_egress_port #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           req_in,
    input  logic [NUM_SRC*DATA_W-1:0]    data_in_bus,
    input  logic [NUM_SRC*ADDR_W-1:0]    addr_in_bus,
    output logic [NUM_SRC-1:0]           gnt_out,
    input  logic                         ready_in,
    output logic                         valid_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [ADDR_W-1:0]            addr_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         full_out
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] scan_idx;
    logic             gnt_any;
    logic             pop;
    logic             space;
    word_t            wr_word;
    word_t            head;

    assign pop   = valid_out & ready_in;
    assign space = ~full_out | pop;

    // Scan from rr_ptr upward; reset gating keeps X requests from leaking into grants.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        gnt_out  = '0;
        if (reset && space) begin
            for (int off = 0; off < NUM_SRC; off++) begin
                scan_idx = SRC_W'((int'(rr_ptr) + off) % NUM_SRC);
                if (!gnt_any && req_in[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (gnt_any) gnt_out[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

    assign wr_word.data = data_in_bus[gnt_idx*DATA_W +: DATA_W];
    assign wr_word.addr = addr_in_bus[gnt_idx*ADDR_W +: ADDR_W];

    sync_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push   (gnt_any),
        .wr_dat (wr_word),
        .pop    (pop),
        .rd_dat (head),
        .count  (count_out)
    );

    assign full_out  = (count_out == CNT_W'(DEPTH));
    assign valid_out = (count_out != '0);
    assign data_out  = valid_out ? head.data : '0;
    assign addr_out  = valid_out ? head.addr : '0;
endmodule

// File: tb/tb_switch_egress_port.sv
// Scoreboard bench for switch_egress_port: stimulus queues expected words, a monitor checks each pop.

module tb_switch_egress_port;
    logic        clk;
    logic        reset;
    logic [3:0]  req_in;
    logic [31:0] data_in_bus;
    logic [31:0] addr_in_bus;
    logic [3:0]  gnt_out;
    logic        ready_in;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [7:0]  addr_out;
    logic [3:0]  count_out;
    logic        full_out;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_q [$];
    logic [15:0] mon_word;

    switch_egress_port #(
        .NUM_SRC (4),
        .DATA_W  (8),
        .ADDR_W  (8),
        .DEPTH   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .data_in_bus (data_in_bus),
        .addr_in_bus (addr_in_bus),
        .gnt_out     (gnt_out),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .addr_out    (addr_out),
        .count_out   (count_out),
        .full_out    (full_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_src(input int i, input logic [7:0] d, input logic [7:0] a);
        data_in_bus[i*8 +: 8] = d;
        addr_in_bus[i*8 +: 8] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // src < 0 means no grant is expected; otherwise that source's word joins the scoreboard.
    task automatic expect_gnt(input string name, input int src);
        logic [3:0] g;
        g = (src < 0) ? 4'b0000 : (4'b0001 << src);
        @(negedge clk);
        check(name, {28'd0, gnt_out}, {28'd0, g});
        if (src >= 0) exp_q.push_back({addr_in_bus[src*8 +: 8], data_in_bus[src*8 +: 8]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset && valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got %0h/%0h, expected no output", addr_out, data_out);
                end else begin
                    mon_word = exp_q.pop_front();
                    check("out_word", {16'd0, addr_out, data_out}, {16'd0, mon_word});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int src_seq [8];
        src_seq = '{3, 0, 1, 2, 3, 0, 1, 2};
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        ready_in = 1'b1;
        req_in = 4'b1111;
        data_in_bus = '0;
        addr_in_bus = '0;
        for (int i = 0; i < 4; i++) set_src(i, 8'(8'hC0 + i), 8'(i));

        // Reset hold with all sources requesting.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt",   {28'd0, gnt_out},   32'd0);
            check("rst_valid", {31'd0, valid_out}, 32'd0);
            check("rst_data",  {24'd0, data_out},  32'd0);
            check("rst_addr",  {24'd0, addr_out},  32'd0);
            check("rst_count", {28'd0, count_out}, 32'd0);
            check("rst_full",  {31'd0, full_out},  32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        expect_gnt("rst_first_gnt", 0);
        step();
        req_in = 4'b0000;
        @(negedge clk);
        check("first_count", {28'd0, count_out}, 32'd1);
        step();
        step();

        // Single word latency, rr_ptr now at 1.
        set_src(2, 8'hA5, 8'h02);
        req_in = 4'b0100;
        expect_gnt("single_gnt", 2);
        check("single_valid_n", {31'd0, valid_out}, 32'd0);
        step();
        req_in = 4'b0000;
        @(negedge clk);
        check("single_valid_n1", {31'd0, valid_out}, 32'd1);
        step();
        @(negedge clk);
        check("single_valid_n2", {31'd0, valid_out}, 32'd0);
        step();

        // Round robin with all sources requesting; rr_ptr starts at 3.
        for (int i = 0; i < 4; i++) set_src(i, 8'(8'h30 + i), 8'(i));
        req_in = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            expect_gnt("rr_gnt", src_seq[k]);
            step();
        end
        req_in = 4'b0000;
        repeat (3) step();

        // Fill with ready low; rr_ptr at 3 so source 1 wins each scan.
        ready_in = 1'b0;
        req_in = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            set_src(1, 8'(8'h10 + k), 8'h01);
            expect_gnt("fill_gnt", 1);
            if (k > 0) check("fill_head", {24'd0, data_out}, 32'h10);
            step();
        end
        set_src(1, 8'h18, 8'h01);
        expect_gnt("full_gnt", -1);
        check("full_count", {28'd0, count_out}, 32'd8);
        check("full_flag",  {31'd0, full_out},  32'd1);
        check("full_head",  {24'd0, data_out},  32'h10);
        check("full_valid", {31'd0, valid_out}, 32'd1);
        step();
        repeat (2) begin
            expect_gnt("stall_gnt", -1);
            check("stall_data", {24'd0, data_out}, 32'h10);
            check("stall_addr", {24'd0, addr_out}, 32'h01);
            step();
        end

        // Push and pop together while full; rr_ptr at 2 so source 3 wins.
        set_src(3, 8'h33, 8'h03);
        req_in = 4'b1000;
        ready_in = 1'b1;
        expect_gnt("pushpop_gnt", 3);
        check("pushpop_count_pre", {28'd0, count_out}, 32'd8);
        step();
        req_in = 4'b0000;
        @(negedge clk);
        check("pushpop_count_post", {28'd0, count_out}, 32'd8);
        repeat (10) step();
        @(negedge clk);
        check("drain_count", {28'd0, count_out}, 32'd0);
        check("drain_queue", exp_q.size(), 32'd0);
        step();

        // Queue five words, then reset between edges.
        ready_in = 1'b0;
        req_in = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_src(0, 8'(8'h50 + k), 8'h00);
            expect_gnt("mid_gnt", 0);
            step();
        end
        req_in = 4'b0000;
        @(negedge clk);
        check("mid_count", {28'd0, count_out}, 32'd5);
        check("mid_head",  {24'd0, data_out},  32'h50);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid_out}, 32'd0);
        check("arst_data",  {24'd0, data_out},  32'd0);
        check("arst_addr",  {24'd0, addr_out},  32'd0);
        check("arst_count", {28'd0, count_out}, 32'd0);
        check("arst_full",  {31'd0, full_out},  32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 8'(8'hE0 + i), 8'(8'h40 + i));
        req_in = 4'b1111;
        expect_gnt("post_rst_gnt", 0);
        check("post_rst_count", {28'd0, count_out}, 32'd0);
        step();
        req_in = 4'b0000;
        repeat (4) step();
        @(negedge clk);
        check("final_count", {28'd0, count_out}, 32'd0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/switch_egress_port.md
Name: switch_egress_port

Overview:
- Output-side (upstream) end of the 4-port switch.
- Arbitrates among the switch's input ports competing for this egress and queues their words in a FIFO.
- Presents the head-of-queue on the upstream interface (valid_out/addr_out/data_out) with ready-based flow control.
- Instantiated once per output port; it is the counterpart of the downstream input-port driver interface.

Parameters:
- NUM_SRC, 4, number of requesting input ports. Fixed at 4 for this switch.
- DATA_W, 8, data word width.
- ADDR_W, 8, address field width carried with each word.
- DEPTH, 8, FIFO entries. Power of two, ≥2.

Ports:
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_in  input  NUM_SRC  per-source request; source holds req/data/addr until granted.
- data_in_bus  input  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- addr_in_bus  input  NUM_SRC*ADDR_W  per-source address, same packing.
- gnt_out  output  NUM_SRC  one-hot grant, combinational, same cycle as push.
- ready_in  input  1  upstream consumer can accept this cycle.
- valid_out  output  1  head word valid.
- data_out  output  DATA_W  head data.
- addr_out  output  ADDR_W  head address.
- count_out  output  $clog2(DEPTH+1)  current occupancy.
- full_out  output  1  count_out==DEPTH.

Behaviour:
- Reset (reset==0, asynchronous):
  - count=0, rd_ptr=wr_ptr=0, rr_ptr=0, FIFO contents discarded.
  - valid_out=0, data_out=0, addr_out=0, gnt_out=0, full_out=0.
  - Applies mid-operation; queued words are lost with no partial output.
- Pop: pop = valid_out & ready_in.
- Space: space = (count<DEPTH) | pop. Simultaneous push and pop when full is allowed.
- Arbiter (round-robin):
  - When space and any req_in bit is set, grant the first requesting source scanning rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - Exactly one gnt_out bit high; push that source's data/addr at the clock edge.
  - After a grant to source i, rr_ptr ← (i+1) mod NUM_SRC. With no grant, rr_ptr is unchanged.
  - No space → gnt_out=0 and no push. Never overflow; never drop.
- Push/pop pointers wrap mod DEPTH.
  - count ← count + push − pop.
  - Push and pop in the same cycle leave count unchanged.
- Output:
  - valid_out = (count!=0), driven from registered state.
  - data_out/addr_out = entry at rd_ptr when valid_out, else forced to 0.
  - Words leave in push order.
- Latency: word granted in cycle N → valid_out=1 with that word in cycle N+1 if the FIFO was empty. Pop on an empty FIFO is impossible (valid_out=0).
- Stall: while valid_out=1 and ready_in=0, data_out/addr_out/valid_out are held stable (protocol invariant).
- Empty with a push in the same cycle: no bypass; the word appears next cycle.
- X on req_in during reset is ignored; gnt_out stays 0 while reset==0.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with req_in=4'b1111 → gnt_out=0, valid_out=0, data_out=0, addr_out=0, count_out=0. Release reset → first grant to source 0.
- Single word latency: source 2 requests with data 8'hA5, addr 8'h02 in cycle N, ready_in=1 → gnt_out=4'b0100 in N; valid_out=1, data_out=A5, addr_out=02 in N+1; valid_out=0 in N+2.
- Round-robin fairness: all four sources request continuously, ready_in=1 → grants cycle 0,1,2,3,0,1… and output order matches grant order.
- Full/backpressure: ready_in=0 with source 1 pushing 8 words 8'h10..8'h17 → count_out=8, full_out=1, gnt_out=0 on the 9th request. data_out stays 8'h10 throughout.
- Simultaneous push/pop at full: FIFO full, ready_in=1, source 3 requesting → grant in the same cycle and count_out stays 8. Output sequence continues 10,11,…,17, then source 3's word.
- Reset mid-operation: 5 words queued; drive reset=0 asynchronously between edges → outputs zero immediately; after release count_out=0 and rr_ptr restarts at source 0.
